encode42_serializer: RTL and testbench
======================================

// Module: encode42_serializer
// PURPOSE
//  Binary encoder companion to the lab 2-to-4 one-hot decoder.
//  Captures an N-bit request vector and emits the binary index of each set bit,
//  lowest index first, one index per valid/ready transfer.
//  Pulses done after the last index is accepted.
//  Sits between a multi-hot request source and any consumer of binary select
//  codes (e.g. a downstream 2-to-4 decoder); round-trips decode->encode in lab benches.
// PARAMETERS
//  N  4  width of request vector (>=2)
//  W  2  index width; must equal $clog2(N)
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous reset, active-low
//  req_in     in   N  request vector, sampled only when load accepted
//  load       in   1  capture req_in (accepted only in IDLE)
//  out_idx    out  W  binary index of lowest pending bit
//  out_valid  out  1  out_idx is valid
//  out_ready  in   1  consumer accepts out_idx this cycle
//  busy       out  1  high while in SCAN
//  done       out  1  one-cycle pulse after final transfer or after an empty load
//  err        out  1  one-cycle pulse: load seen while busy (request dropped)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, pending=0.
//   All outputs 0 (out_idx=0, out_valid=0, busy=0, done=0, err=0).
//  Regs: state{IDLE,SCAN}, pending[N-1:0], done_r, err_r.
//   All update on rising clk only.
//  IDLE, load=1, req_in!=0: pending<=req_in; state<=SCAN. Next cycle busy=1, out_valid=1.
//  IDLE, load=1, req_in==0: stay IDLE; done=1 next cycle; no valid is ever raised.
//  SCAN:
//   - out_valid=1.
//   - out_idx = index of lowest set bit of pending (combinational from pending register).
//  Transfer = out_valid & out_ready at a rising edge. On transfer, clear that bit of pending.
//   - If it was the last set bit: state<=IDLE; done=1 for the next cycle only.
//  No transfer: pending, out_idx and out_valid hold unchanged; no timeout.
//  Throughput: 1 index per cycle with out_ready held high.
//   Load-to-first-valid latency = 1 cycle.
//  load while state=SCAN: ignored, pending unaffected; err=1 for the next cycle only.
//   Repeated loads give repeated err pulses.
//  done and a new load in the same cycle: legal (state is IDLE); the load is accepted.
//  out_idx when out_valid=0: drive 0.
//  Reset mid-SCAN: pending cleared immediately, no done pulse, out_valid drops asynchronously.
//  Index arithmetic: W-bit unsigned, range 0..N-1; no wrap.
//   Bits of req_in above N-1 do not exist.
// TESTING
//  1. rst_n=0 then release; idle 3 cycles -> all outputs 0, busy=0.
//  2. load, req_in=4'b1010, out_ready=1 -> valid idx 1 at t+1, idx 3 at t+2;
//     done=1 at t+3, busy=0.
//  3. load, req_in=4'b1111, out_ready toggled 1,0,1,0,... ->
//     idx 0,1,2,3 each held stable while ready=0; exactly 4 transfers then done.
//  4. load, req_in=4'b0000 -> done=1 at t+1, out_valid never 1, busy stays 0.
//  5. load 4'b0110 then load 4'b1001 at t+1 (busy) -> err=1 at t+2;
//     output sequence stays 1,2; a new load is accepted in the done cycle.
//  6. load 4'b1100; assert rst_n=0 mid-SCAN between edges ->
//     out_valid=0 and busy=0 immediately; no done pulse; next load works normally.

Source files
------------

// File: rtl/encode42_serializer.sv
// Multi-hot to binary-index serializer: captures a request vector and hands out
// the index of each set bit, lowest first, over a valid/ready link; pulses done at the end.
module encode42_serializer #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_in,
    input  logic         load,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t       state_reg, state_next;
    logic [N-1:0] pending_reg, pending_next;
    logic         done_reg, done_next;
    logic         err_reg, err_next;

    // seen[i] is high when any pending bit below i is set; lowest is the one-hot
    // mask of the lowest pending bit and idx_chain ORs its index out.
    logic [N-1:0] seen;
    logic [N-1:0] lowest;
    logic [W-1:0] idx_chain [0:N];
    logic [N-1:0] pending_cleared;
    logic         transfer;

    assign seen[0]      = 1'b0;
    assign idx_chain[0] = '0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_prio
            localparam logic [W-1:0] GI_IDX = W'(gi);
            assign lowest[gi]       = pending_reg[gi] & ~seen[gi];
            assign idx_chain[gi+1]  = idx_chain[gi] | (lowest[gi] ? GI_IDX : '0);
            if (gi < N - 1) begin : g_seen
                assign seen[gi+1] = seen[gi] | pending_reg[gi];
            end
        end
    endgenerate

    assign pending_cleared = pending_reg & ~lowest;
    assign out_valid       = (state_reg == SCAN);
    assign busy            = (state_reg == SCAN);
    assign out_idx         = out_valid ? idx_chain[N] : '0;
    assign transfer        = out_valid & out_ready;
    assign done            = done_reg;
    assign err             = err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        done_next    = 1'b0;
        err_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load) begin
                    if (|req_in) begin
                        pending_next = req_in;
                        state_next   = SCAN;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            SCAN: begin
                // A load arriving mid-scan is dropped but flagged.
                if (load) begin
                    err_next = 1'b1;
                end
                if (transfer) begin
                    pending_next = pending_cleared;
                    if (pending_cleared == '0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_encode42_serializer.sv
// Randomized scoreboard bench for encode42_serializer: a transaction-level model
// queues expected indices and flags; a negedge monitor compares DUT outputs.
module tb_encode42_serializer;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req_in = '0;
    logic         load = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_idx;
    logic         out_valid;
    logic         busy;
    logic         done;
    logic         err;

    encode42_serializer #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .load      (load),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: outstanding indices plus the flags expected this cycle.
    int exp_q[$];
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit m_err  = 1'b0;
    int m_left = 0;

    task automatic chk(input string nm, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_edge(input bit ld, input logic [N-1:0] rq, input bit rdy);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (m_busy) begin
            if (ld) m_err = 1'b1;
            if (rdy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (ld) begin
            if (rq != '0) begin
                m_busy = 1'b1;
                m_left = 0;
                for (int i = 0; i < N; i++) begin
                    if (rq[i]) begin
                        exp_q.push_back(i);
                        m_left++;
                    end
                end
            end else begin
                m_done = 1'b1;
            end
        end
    endtask

    // Called 1 time unit after a rising edge; inputs apply to the next edge.
    task automatic step(input bit ld, input logic [N-1:0] rq, input bit rdy);
        load      = ld;
        req_in    = rq;
        out_ready = rdy;
        @(posedge clk);
        model_edge(ld, rq, rdy);
        #1;
        $display("txn load=%0b req=%b ready=%0b -> model busy=%0b done=%0b err=%0b pending=%0d",
                 ld, rq, rdy, m_busy, m_done, m_err, exp_q.size());
    endtask

    // mode 0: ready held high, 1: ready toggles 1,0,1,..., 2: random ready
    task automatic drain(input int mode);
        int guard;
        guard = 0;
        while (m_busy && guard < 64) begin
            case (mode)
                0:       step(1'b0, '0, 1'b1);
                1:       step(1'b0, '0, (guard % 2) == 0);
                default: step(1'b0, '0, 1'($urandom_range(0, 1)));
            endcase
            guard++;
        end
        n_vec++;
        if (m_busy) begin
            n_bad++;
            $display("FAIL drain_timeout: got busy after %0d cycles, expected idle", guard);
        end
    endtask

    always @(negedge clk) begin
        chk("out_valid", int'(out_valid), int'(m_busy));
        chk("busy", int'(busy), int'(m_busy));
        chk("done", int'(done), int'(m_done));
        chk("err", int'(err), int'(m_err));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_valid: got idx %0d, expected no output", out_idx);
            end else begin
                chk("out_idx", int'(out_idx), exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end else begin
            chk("idx_when_invalid", int'(out_idx), 0);
        end
    end

    initial begin
        logic [N-1:0] rq;
        bit           ld;
        bit           rdy;

        // 1. reset and idle
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) step(1'b0, '0, 1'b0);

        // 2. two-bit request, ready high
        step(1'b1, 4'b1010, 1'b1);
        drain(0);
        step(1'b0, '0, 1'b0);

        // 3. all bits, ready toggling
        step(1'b1, 4'b1111, 1'b1);
        drain(1);
        step(1'b0, '0, 1'b0);

        // 4. empty load
        step(1'b1, 4'b0000, 1'b1);
        repeat (2) step(1'b0, '0, 1'b1);

        // 5. load while busy, then reload in the done cycle
        step(1'b1, 4'b0110, 1'b1);
        step(1'b1, 4'b1001, 1'b1);
        drain(0);
        step(1'b1, 4'b0101, 1'b1);
        drain(0);
        step(1'b0, '0, 1'b0);

        // 6. asynchronous reset in the middle of a scan
        step(1'b1, 4'b1100, 1'b0);
        step(1'b0, '0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        m_busy = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_left = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0);
        step(1'b1, 4'b1100, 1'b1);
        drain(0);
        step(1'b0, '0, 1'b0);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            ld  = ($urandom_range(0, 3) == 0);
            rq  = N'($urandom);
            rdy = ($urandom_range(0, 2) != 0);
            step(ld, rq, rdy);
        end
        drain(2);
        repeat (2) step(1'b0, '0, 1'b0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
